// File: rtl/set12_controller.sv
// 12-hour time-set sequencer: AM/PM -> hour -> minute, with wrap edits and blink phase.
// Optional hold-to-repeat stepping is built when SET12_AUTO_REPEAT_EN is defined.
module set12_controller #(
  parameter int QUARTER_CYCLES = 12_500_000,
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_RATE    = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_cancel,
  input  logic       cur_isPM,
  input  logic [3:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [1:0] currentState,
  output logic       real_quarter,
  output logic       isPM,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic       commit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AMPM = 2'd1,
    S_HOUR = 2'd2,
    S_MIN  = 2'd3
  } state_e;

  localparam int CW =
    (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(QUARTER_CYCLES - 1);

  state_e        state_q, state_d;
  logic          is_pm_q, is_pm_d;
  logic [3:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic          rq_q, rq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          commit_q, commit_d;
  logic [3:0]    btn_q;
  logic          armed_q;

  logic mode_e, up_e, dn_e, cancel_e;
  logic cancel_act, chg;
  logic step_up, step_dn;
  logic rep_up, rep_dn;
  logic rep_active;
  logic [3:0] ld_hours;
  logic [5:0] ld_minutes;

  // Edges are masked for the first clock so a button held through reset is ignored.
  assign mode_e   = btn_mode   & ~btn_q[0] & armed_q;
  assign up_e     = btn_up     & ~btn_q[1] & armed_q;
  assign dn_e     = btn_down   & ~btn_q[2] & armed_q;
  assign cancel_e = btn_cancel & ~btn_q[3] & armed_q;

  assign cancel_act = cancel_e & (state_q != S_IDLE);
  assign chg        = cancel_act | mode_e;

  assign step_up = (up_e & ~dn_e) | rep_up;
  assign step_dn = (dn_e & ~up_e) | rep_dn;

  assign ld_hours =
    ((cur_hours == 4'd0) || (cur_hours > 4'd12)) ? 4'd12 : cur_hours;
  assign ld_minutes =
    (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;

`ifdef SET12_AUTO_REPEAT_EN
  logic [31:0] hold_q, hold_d;
  logic        rep_q, rep_d;
  logic        held_one;

  assign held_one = (btn_up ^ btn_down) & (state_q != S_IDLE);

  always_comb begin
    hold_d = hold_q;
    rep_d  = rep_q;
    rep_up = 1'b0;
    rep_dn = 1'b0;
    if (!held_one || up_e || dn_e || chg) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (!rep_q) begin
      if (hold_q >= 32'(REPEAT_DELAY - 1)) begin
        hold_d = '0;
        rep_d  = 1'b1;
        rep_up = btn_up;
        rep_dn = btn_down;
      end else begin
        hold_d = hold_q + 32'd1;
      end
    end else begin
      if (hold_q >= 32'(REPEAT_RATE - 1)) begin
        hold_d = '0;
        rep_up = btn_up;
        rep_dn = btn_down;
      end else begin
        hold_d = hold_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

  assign rep_active = rep_q;
`else
  assign rep_up     = 1'b0;
  assign rep_dn     = 1'b0;
  assign rep_active = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    is_pm_d   = is_pm_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    commit_d  = 1'b0;
    rq_d      = rq_q;
    cnt_d     = cnt_q;

    if (cancel_act) begin
      state_d = S_IDLE;
    end else if (mode_e) begin
      unique case (state_q)
        S_IDLE: begin
          state_d   = S_AMPM;
          is_pm_d   = cur_isPM;
          hours_d   = ld_hours;
          minutes_d = ld_minutes;
        end
        S_AMPM: state_d = S_HOUR;
        S_HOUR: state_d = S_MIN;
        S_MIN: begin
          state_d  = S_IDLE;
          commit_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (step_up ^ step_dn) begin
      unique case (state_q)
        S_AMPM: is_pm_d = ~is_pm_q;
        S_HOUR: begin
          if (step_up)
            hours_d = (hours_q >= 4'd12) ? 4'd1 : hours_q + 4'd1;
          else
            hours_d = (hours_q <= 4'd1) ? 4'd12 : hours_q - 4'd1;
        end
        S_MIN: begin
          if (step_up)
            minutes_d = (minutes_q >= 6'd59) ? 6'd0 : minutes_q + 6'd1;
          else
            minutes_d = (minutes_q == 6'd0) ? 6'd59 : minutes_q - 6'd1;
        end
        default: ;
      endcase
    end

    // A newly selected field always starts in the visible phase.
    if (state_d != state_q || state_q == S_IDLE) begin
      cnt_d = '0;
      rq_d  = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      rq_d  = ~rq_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_pm_q   <= 1'b0;
      hours_q   <= 4'd12;
      minutes_q <= 6'd0;
      rq_q      <= 1'b1;
      cnt_q     <= '0;
      commit_q  <= 1'b0;
      btn_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_pm_q   <= is_pm_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      rq_q      <= rq_d;
      cnt_q     <= cnt_d;
      commit_q  <= commit_d;
      btn_q     <= {btn_cancel, btn_down, btn_up, btn_mode};
      armed_q   <= 1'b1;
    end
  end

  assign currentState = state_q;
  assign real_quarter = rq_q | rep_active;
  assign isPM         = is_pm_q;
  assign hours        = hours_q;
  assign minutes      = minutes_q;
  assign commit       = commit_q;

endmodule

// File: tb/tb_set12_controller.sv
// Directed-vector bench for set12_controller (QUARTER_CYCLES = 4).
module tb_set12_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_up, btn_down, btn_cancel;
  logic       cur_isPM;
  logic [3:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [1:0] currentState;
  logic       real_quarter, isPM, commit;
  logic [3:0] hours;
  logic [5:0] minutes;

  int vec_cnt = 0;
  int err_cnt = 0;

  set12_controller #(.QUARTER_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .btn_cancel(btn_cancel),
    .cur_isPM(cur_isPM), .cur_hours(cur_hours),
    .cur_minutes(cur_minutes),
    .currentState(currentState), .real_quarter(real_quarter),
    .isPM(isPM), .hours(hours), .minutes(minutes),
    .commit(commit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       m, u, d, c;
    logic [1:0] st;
    logic       pm;
    logic [3:0] hr;
    logic [5:0] mn;
    logic       cm;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] b);
    {btn_cancel, btn_down, btn_up, btn_mode} = b;
  endtask

  task automatic press(input logic [3:0] b);
    drive(b);
    tick();
    drive(4'b0000);
    tick();
  endtask

  localparam logic [3:0] M = 4'b0001;
  localparam logic [3:0] U = 4'b0010;
  localparam logic [3:0] D = 4'b0100;
  localparam logic [3:0] C = 4'b1000;

  logic [11:0] blink_pat;

  initial begin
    tbl[0]  = '{1,0,0,0, 2'd1, 1, 4'd11, 6'd58, 0};
    tbl[1]  = '{0,1,0,0, 2'd1, 0, 4'd11, 6'd58, 0};
    tbl[2]  = '{0,0,1,0, 2'd1, 1, 4'd11, 6'd58, 0};
    tbl[3]  = '{1,0,0,0, 2'd2, 1, 4'd11, 6'd58, 0};
    tbl[4]  = '{0,1,0,0, 2'd2, 1, 4'd12, 6'd58, 0};
    tbl[5]  = '{0,1,0,0, 2'd2, 1, 4'd1,  6'd58, 0};
    tbl[6]  = '{0,0,1,0, 2'd2, 1, 4'd12, 6'd58, 0};
    tbl[7]  = '{0,0,1,0, 2'd2, 1, 4'd11, 6'd58, 0};
    tbl[8]  = '{0,0,1,0, 2'd2, 1, 4'd10, 6'd58, 0};
    tbl[9]  = '{0,1,1,0, 2'd2, 1, 4'd10, 6'd58, 0};
    tbl[10] = '{1,0,0,0, 2'd3, 1, 4'd10, 6'd58, 0};
    tbl[11] = '{0,1,0,0, 2'd3, 1, 4'd10, 6'd59, 0};
    tbl[12] = '{0,1,0,0, 2'd3, 1, 4'd10, 6'd0,  0};
    tbl[13] = '{0,1,0,0, 2'd3, 1, 4'd10, 6'd1,  0};
    tbl[14] = '{0,0,1,0, 2'd3, 1, 4'd10, 6'd0,  0};
    tbl[15] = '{0,0,1,0, 2'd3, 1, 4'd10, 6'd59, 0};
    tbl[16] = '{0,1,1,0, 2'd3, 1, 4'd10, 6'd59, 0};
    tbl[17] = '{1,0,0,0, 2'd0, 1, 4'd10, 6'd59, 1};
    tbl[18] = '{0,1,0,0, 2'd0, 1, 4'd10, 6'd59, 0};
    tbl[19] = '{0,0,0,1, 2'd0, 1, 4'd10, 6'd59, 0};
    tbl[20] = '{1,0,0,0, 2'd1, 1, 4'd11, 6'd58, 0};
    tbl[21] = '{1,0,0,0, 2'd2, 1, 4'd11, 6'd58, 0};
    tbl[22] = '{0,1,0,0, 2'd2, 1, 4'd12, 6'd58, 0};
    tbl[23] = '{0,0,0,1, 2'd0, 1, 4'd12, 6'd58, 0};

    rst_n = 1'b0;
    drive(4'b0000);
    cur_isPM = 1'b1;
    cur_hours = 4'd11;
    cur_minutes = 6'd58;
    tick();
    tick();
    chk("rst.st", currentState, 0);
    chk("rst.pm", isPM, 0);
    chk("rst.hr", hours, 12);
    chk("rst.mn", minutes, 0);
    chk("rst.rq", real_quarter, 1);
    chk("rst.cm", commit, 0);
    #4 rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 24; i++) begin
      btn_mode   = tbl[i].m;
      btn_up     = tbl[i].u;
      btn_down   = tbl[i].d;
      btn_cancel = tbl[i].c;
      tick();
      chk($sformatf("v%0d.st", i), currentState, tbl[i].st);
      chk($sformatf("v%0d.pm", i), isPM, tbl[i].pm);
      chk($sformatf("v%0d.hr", i), hours, tbl[i].hr);
      chk($sformatf("v%0d.mn", i), minutes, tbl[i].mn);
      chk($sformatf("v%0d.cm", i), commit, tbl[i].cm);
      drive(4'b0000);
      tick();
      chk($sformatf("v%0d.cm_after", i), commit, 0);
      chk($sformatf("v%0d.st_hold", i), currentState, tbl[i].st);
    end

    // Out-of-range live time is clamped on entry.
    cur_hours = 4'd0;
    cur_minutes = 6'd63;
    press(M);
    chk("clamp0.hr", hours, 12);
    chk("clamp0.mn", minutes, 0);
    press(C);
    cur_hours = 4'd13;
    cur_minutes = 6'd60;
    press(M);
    chk("clamp13.hr", hours, 12);
    chk("clamp13.mn", minutes, 0);
    press(C);
    cur_hours = 4'd1;
    cur_minutes = 6'd59;
    press(M);
    chk("noclamp.hr", hours, 1);
    chk("noclamp.mn", minutes, 59);
    press(M);
    // A held up level gives a single step.
    drive(U);
    repeat (6) tick();
    chk("held.hr", hours, 2);
    drive(4'b0000);
    tick();
    press(C);
    chk("cancel.st", currentState, 0);
    chk("cancel.rq_idle", real_quarter, 1);

    // Blink pattern 1111 0000 1111 from state entry.
    blink_pat = 12'b1111_0000_1111;
    drive(M);
    tick();
    drive(4'b0000);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("blink%0d", i), real_quarter, blink_pat[11-i]);
      tick();
    end
    chk("blink12", real_quarter, 0);
    tick();
    chk("blink13", real_quarter, 0);
    drive(M);
    tick();
    drive(4'b0000);
    chk("restart.st", currentState, 2);
    chk("restart.rq0", real_quarter, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("restart.rq%0d", i), real_quarter, 1);
    end
    tick();
    chk("restart.fall", real_quarter, 0);

    // Asynchronous reset while in SET_MIN.
    press(M);
    chk("premin.st", currentState, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.st", currentState, 0);
    chk("arst.pm", isPM, 0);
    chk("arst.hr", hours, 12);
    chk("arst.mn", minutes, 0);
    chk("arst.rq", real_quarter, 1);
    chk("arst.cm", commit, 0);

    // Mode held through reset release gives no edge.
    btn_mode = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("heldrst.st", currentState, 0);
    drive(4'b0000);
    tick();
    press(M);
    chk("postrst.st", currentState, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
